seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 7-segment display scanner with frame-synchronous updates
//
// Parameters:
//   NDIGITS   number of multiplexed digits (1..8)
//   PRESCALE  clocks per digit slot (>=2)
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   load_i     capture value_i/dp_i this cycle
//   value_i    hex nibbles, nibble k drives digit k (digit 0 least significant)
//   dp_i       decimal point request per digit, 1 = lit
//   lzb_i      leading-zero blanking request
//   seg_o      segments a..g on bits 0..6, active-low
//   dp_o       decimal point segment, active-low
//   an_o       digit enables, active-low, at most one low
//   pending_o  staged update waiting for the frame boundary
//   frame_o    one-clock pulse at the start of each frame
// Optional feature: leading-zero blanking is built only when SEG7_SCAN_LZB_EN is defined.

module seg7_scan #(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [4*NDIGITS-1:0]   value_i,
    input  logic [NDIGITS-1:0]     dp_i,
    input  logic                   lzb_i,
    output logic [6:0]             seg_o,
    output logic                   dp_o,
    output logic [NDIGITS-1:0]     an_o,
    output logic                   pending_o,
    output logic                   frame_o
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [PW-1:0] CNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

    logic [PW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*NDIGITS-1:0]   stage_val;
    logic [NDIGITS-1:0]     stage_dp;
    logic [4*NDIGITS-1:0]   disp_val;
    logic [NDIGITS-1:0]     disp_dp;

    logic                   tick;
    logic                   boundary;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic [NDIGITS-1:0]     blank_vec;
    logic                   blank_cur;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick     = (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);
    assign cur_nib  = disp_val[4*int'(idx) +: 4];
    assign cur_dp   = disp_dp[idx];

    // A digit k>0 is a leading zero when it and every digit above it is zero
    // and carries no decimal point; scan from the top down accumulating that.
    always_comb begin
        logic upper_clear;
        blank_vec   = '0;
        upper_clear = 1'b1;
        for (int k = NDIGITS - 1; k >= 1; k--) begin
            upper_clear  = upper_clear && (disp_val[4*k +: 4] == 4'h0) && !disp_dp[k];
            blank_vec[k] = upper_clear;
        end
    end

`ifdef SEG7_SCAN_LZB_EN
    assign blank_cur = lzb_i && blank_vec[idx];
`else
    logic unused_lzb;
    assign unused_lzb = lzb_i ^ (|blank_vec);
    assign blank_cur  = 1'b0;
`endif

    // Scan timing: prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            frame_o <= 1'b0;
        end else begin
            frame_o <= boundary;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Staging and display registers. Updates land only at the frame boundary
    // so a frame never shows a mix of old and new digits. A load that lands
    // on the boundary itself bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_val <= '0;
            stage_dp  <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            pending_o <= 1'b0;
        end else begin
            if (load_i) begin
                stage_val <= value_i;
                stage_dp  <= dp_i;
            end
            if (boundary) begin
                pending_o <= 1'b0;
                if (load_i) begin
                    disp_val <= value_i;
                    disp_dp  <= dp_i;
                end else if (pending_o) begin
                    disp_val <= stage_val;
                    disp_dp  <= stage_dp;
                end
            end else if (load_i) begin
                pending_o <= 1'b1;
            end
        end
    end

    // Registered pin drivers. The first prescaler count of each slot keeps
    // every anode off so the previous digit's segments cannot ghost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
            an_o  <= '1;
        end else begin
            an_o  <= (cnt == '0) ? '1 : ~(NDIGITS'(1) << idx);
            seg_o <= blank_cur ? 7'h7F : seg_decode(cur_nib);
            dp_o  <= blank_cur ? 1'b1 : ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan (NDIGITS=4, PRESCALE=4)

module tb_seg7_scan;

    logic        clk;
    logic        rst_n;
    logic        load_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        lzb_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        pending_o;
    logic        frame_o;

    int n_total = 0;
    int n_bad   = 0;

    logic [6:0] got_seg [4];
    logic       got_dp  [4];

    seg7_scan #(.NDIGITS(4), .PRESCALE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_i),
        .value_i   (value_i),
        .dp_i      (dp_i),
        .lzb_i     (lzb_i),
        .seg_o     (seg_o),
        .dp_o      (dp_o),
        .an_o      (an_o),
        .pending_o (pending_o),
        .frame_o   (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
        logic [27:0] seg;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dpo;   // {digit3 .. digit0}
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", {31'd0, frame_o}, 32'd1);
    endtask

    // Called at the negedge on which frame_o is seen high.
    task automatic read_digits();
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 2 : 4) @(negedge clk);
            got_seg[k] = seg_o;
            got_dp[k]  = dp_o;
            check($sformatf("an_digit%0d", k), {28'd0, an_o}, {28'd0, ~(4'b0001 << k)});
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        value_i = v;
        dp_i    = d;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    task automatic check_digits(input string tag, input logic [27:0] seg, input logic [3:0] dpo);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_seg%0d", tag, k), {25'd0, got_seg[k]}, {25'd0, seg[7*k +: 7]});
            check($sformatf("%s_dp%0d", tag, k), {31'd0, got_dp[k]}, {31'd0, dpo[k]});
        end
    endtask

    initial begin
        logic [3:0] exp_an;
        logic       all_pending;
        logic [6:0] old_d3;

        vecs[0] = '{16'h0123, 4'b0000, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30}, 4'b1111};
        vecs[1] = '{16'h89AB, 4'b0101, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1010};
        vecs[2] = '{16'hCDEF, 4'b0000, 1'b0, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1111};
        vecs[3] = '{16'h4567, 4'b1000, 1'b0, {7'h19, 7'h12, 7'h02, 7'h78}, 4'b0111};
`ifdef SEG7_SCAN_LZB_EN
        vecs[4] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[6] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
`else
        vecs[4] = '{16'h0050, 4'b0000, 1'b1, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
        vecs[6] = '{16'h0000, 4'b0000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
`endif
        vecs[5] = '{16'h0050, 4'b1000, 1'b1, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0111};
        vecs[7] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};

        rst_n   = 1'b0;
        load_i  = 1'b0;
        value_i = '0;
        dp_i    = '0;
        lzb_i   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state and release scan sequence.
        check("rst_seg", {25'd0, seg_o}, 32'h7F);
        check("rst_dp", {31'd0, dp_o}, 32'd1);
        check("rst_an", {28'd0, an_o}, 32'hF);
        check("rst_pending", {31'd0, pending_o}, 32'd0);
        check("rst_frame", {31'd0, frame_o}, 32'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if ((c - 1) % 4 == 0) exp_an = 4'hF;
            else                  exp_an = ~(4'b0001 << (((c - 1) / 4) % 4));
            check($sformatf("scan_an_c%0d", c), {28'd0, an_o}, {28'd0, exp_an});
            check($sformatf("scan_frame_c%0d", c), {31'd0, frame_o}, {31'd0, (c % 16 == 0)});
        end

        // Table of loads: each loaded at a frame start, checked the next frame.
        for (int i = 0; i < 8; i++) begin
            wait_frame();
            lzb_i = vecs[i].lzb;
            load(vecs[i].value, vecs[i].dp);
            check($sformatf("v%0d_pending", i), {31'd0, pending_o}, 32'd1);
            wait_frame();
            check($sformatf("v%0d_pending_clr", i), {31'd0, pending_o}, 32'd0);
            read_digits();
            check_digits($sformatf("v%0d", i), vecs[i].seg, vecs[i].dpo);
        end
        lzb_i = 1'b0;

        // Mid-frame load held until the boundary (display currently 0x0050).
        wait_frame();
        repeat (5) @(negedge clk);
        load(16'h1A3F, 4'b0000);
        all_pending = 1'b1;
        for (int n = 0; n < 40 && frame_o !== 1'b1; n++) begin
            if (pending_o !== 1'b1) all_pending = 1'b0;
            @(negedge clk);
        end
        old_d3 = seg_o;
        check("mid_pending_held", {31'd0, all_pending}, 32'd1);
        check("mid_frame_seen", {31'd0, frame_o}, 32'd1);
        check("mid_old_digit3", {25'd0, old_d3}, 32'h40);
        check("mid_pending_clr", {31'd0, pending_o}, 32'd0);
        read_digits();
        check_digits("ld1A3F", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1111);

        // Two loads in one frame: last write wins.
        wait_frame();
        repeat (3) @(negedge clk);
        load(16'h0000, 4'b0000);
        repeat (3) @(negedge clk);
        load(16'h1234, 4'b0000);
        wait_frame();
        read_digits();
        check_digits("lww", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);

        // Load exactly on the boundary cycle goes straight to display.
        wait_frame();
        repeat (15) @(negedge clk);
        load(16'hCDEF, 4'b0001);
        check("bnd_frame", {31'd0, frame_o}, 32'd1);
        check("bnd_pending", {31'd0, pending_o}, 32'd0);
        read_digits();
        check_digits("bnd", {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1110);
        @(negedge clk);
        check("bnd_pending_after", {31'd0, pending_o}, 32'd0);

        // Asynchronous reset mid-slot with a pending update.
        wait_frame();
        repeat (6) @(negedge clk);
        load(16'h4567, 4'b1111);
        check("rst2_pending_before", {31'd0, pending_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_seg", {25'd0, seg_o}, 32'h7F);
        check("rst2_dp", {31'd0, dp_o}, 32'd1);
        check("rst2_an", {28'd0, an_o}, 32'hF);
        check("rst2_pending", {31'd0, pending_o}, 32'd0);
        check("rst2_frame", {31'd0, frame_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame();
        check("rst2_pending_after", {31'd0, pending_o}, 32'd0);
        read_digits();
        check_digits("rst2", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
